// File: rtl/line_buffer_bram_if.sv
// Pixel stream and tap-column bundle for line_buffer_bram.
// The master drives pixels and clear; the slave returns one vertical column per beat.
interface line_buffer_bram_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_LINES  = 3,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned ROW_WIDTH  = 16
);
    logic                            clear;
    logic                            in_valid;
    logic [DATA_WIDTH-1:0]           in_data;
    logic                            out_valid;
    logic [NUM_LINES*DATA_WIDTH-1:0] out_taps;
    logic [ADDR_WIDTH-1:0]           out_col;
    logic [ROW_WIDTH-1:0]            out_row;
    logic                            line_done;

    modport master (
        output clear, in_valid, in_data,
        input  out_valid, out_taps, out_col, out_row, line_done
    );

    modport slave (
        input  clear, in_valid, in_data,
        output out_valid, out_taps, out_col, out_row, line_done
    );
endinterface

// File: rtl/line_buffer_bram.sv
// Multi-line pixel buffer: NUM_LINES-1 rotating BRAM banks, all read at the current column,
// so each beat carries the newest pixel plus the same column from the previous rows.
module line_buffer_bram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LINE_WIDTH = 720,
    parameter int unsigned NUM_LINES  = 3,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned ROW_WIDTH  = 16
) (
    input logic              clock,
    input logic              reset,
    line_buffer_bram_if.slave bus
);
    localparam int unsigned NumBanks = NUM_LINES - 1;
    localparam int unsigned BankW    = (NumBanks > 1) ? $clog2(NumBanks) : 1;
    localparam int unsigned PrimW    = $clog2(NUM_LINES);

    localparam logic [ADDR_WIDTH-1:0] LastCol  = ADDR_WIDTH'(LINE_WIDTH - 1);
    localparam logic [BankW-1:0]      LastBank = BankW'(NumBanks - 1);
    localparam logic [PrimW-1:0]      Primed   = PrimW'(NumBanks);

    logic [ADDR_WIDTH-1:0] col_q, col_d, cur_col;
    logic [ROW_WIDTH-1:0]  row_q, row_d, cur_row;
    logic [PrimW-1:0]      primed_q, primed_d, cur_primed;
    logic [BankW-1:0]      wr_bank_q, wr_bank_d, cur_bank;

    logic                  out_valid_q, out_valid_d;
    logic                  line_done_q, line_done_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ADDR_WIDTH-1:0] out_col_q, out_col_d;
    logic [ROW_WIDTH-1:0]  out_row_q, out_row_d;
    logic [BankW-1:0]      tap_bank_q, tap_bank_d;

    logic                                 accept;
    logic [NumBanks-1:0][DATA_WIDTH-1:0]  rd_data;
    logic [NUM_LINES*DATA_WIDTH-1:0]      taps;

    assign accept = bus.in_valid;

    // clear overrides the counters first, so a same-cycle pixel lands at row 0 col 0
    always_comb begin
        cur_col    = bus.clear ? '0 : col_q;
        cur_row    = bus.clear ? '0 : row_q;
        cur_primed = bus.clear ? '0 : primed_q;
        cur_bank   = bus.clear ? '0 : wr_bank_q;

        col_d    = cur_col;
        row_d    = cur_row;
        primed_d = cur_primed;
        wr_bank_d = cur_bank;

        if (accept) begin
            if (cur_col == LastCol) begin
                col_d     = '0;
                row_d     = cur_row + 1'b1;
                wr_bank_d = (cur_bank == LastBank) ? '0 : cur_bank + 1'b1;
                primed_d  = (cur_primed == Primed) ? Primed : cur_primed + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
            end
        end

        out_valid_d = accept && (cur_primed == Primed);
        line_done_d = accept && (cur_col == LastCol);
        data_d      = accept ? bus.in_data : data_q;
        out_col_d   = accept ? cur_col : out_col_q;
        out_row_d   = accept ? cur_row : out_row_q;
        tap_bank_d  = accept ? cur_bank : tap_bank_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col_q       <= '0;
            row_q       <= '0;
            primed_q    <= '0;
            wr_bank_q   <= '0;
            out_valid_q <= 1'b0;
            line_done_q <= 1'b0;
            data_q      <= '0;
            out_col_q   <= '0;
            out_row_q   <= '0;
            tap_bank_q  <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            primed_q    <= primed_d;
            wr_bank_q   <= wr_bank_d;
            out_valid_q <= out_valid_d;
            line_done_q <= line_done_d;
            data_q      <= data_d;
            out_col_q   <= out_col_d;
            out_row_q   <= out_row_d;
            tap_bank_q  <= tap_bank_d;
        end
    end

    for (genvar b = 0; b < NumBanks; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [LINE_WIDTH];
        logic [DATA_WIDTH-1:0] rd_q;

        always_ff @(posedge clock) begin
            if (accept && (cur_bank == BankW'(b))) begin
                mem[cur_col] <= bus.in_data;
            end
        end

        // read-first: the same edge that writes returns the previous row's pixel
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                rd_q <= '0;
            end else if (accept) begin
                rd_q <= mem[cur_col];
            end
        end

        assign rd_data[b] = rd_q;
    end

    // tap k comes from the bank written k rows before the accepting one
    always_comb begin
        int unsigned idx;
        taps = '0;
        taps[0 +: DATA_WIDTH] = data_q;
        for (int k = 1; k < NUM_LINES; k++) begin
            idx = (int'(tap_bank_q) + NumBanks - k) % NumBanks;
            taps[k*DATA_WIDTH +: DATA_WIDTH] = rd_data[BankW'(idx)];
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_taps  = taps;
    assign bus.out_col   = out_col_q;
    assign bus.out_row   = out_row_q;
    assign bus.line_done = line_done_q;
endmodule

// File: tb/tb_line_buffer_bram.sv
// Directed bench for line_buffer_bram with 8-pixel rows and 3 taps; pixel value = row*16+col.
module tb_line_buffer_bram;
    localparam int unsigned DW = 8;
    localparam int unsigned LW = 8;
    localparam int unsigned NL = 3;
    localparam int unsigned AW = 3;
    localparam int unsigned RW = 16;

    logic clock;
    logic reset;
    int   compared;
    int   mismatched;

    line_buffer_bram_if #(
        .DATA_WIDTH(DW), .NUM_LINES(NL), .ADDR_WIDTH(AW), .ROW_WIDTH(RW)
    ) bus ();

    line_buffer_bram #(
        .DATA_WIDTH(DW), .LINE_WIDTH(LW), .NUM_LINES(NL), .ADDR_WIDTH(AW), .ROW_WIDTH(RW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic push(input logic v, input logic [7:0] d, input logic clr);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.clear    = clr;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        bus.clear    = 1'b0;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.clear    = 1'b0;
        bus.in_data  = '0;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    // Streams rows 0..nrows-1 from a freshly zeroed counter state and checks every beat.
    task automatic stream(input string name, input int nrows, input bit gaps);
        logic [23:0] exp_taps;
        logic [23:0] held;
        for (int r = 0; r < nrows; r++) begin
            for (int c = 0; c < LW; c++) begin
                push(1'b1, 8'(r * 16 + c), 1'b0);
                compared++;
                if (bus.out_valid !== (r >= 2)) begin
                    mismatched++;
                    $display("FAIL %s valid r%0d c%0d: got %b want %b", name, r, c,
                             bus.out_valid, (r >= 2));
                end
                compared++;
                if (bus.line_done !== (c == LW - 1)) begin
                    mismatched++;
                    $display("FAIL %s line_done r%0d c%0d: got %b want %b", name, r, c,
                             bus.line_done, (c == LW - 1));
                end
                if (r >= 2) begin
                    exp_taps = {8'((r - 2) * 16 + c), 8'((r - 1) * 16 + c), 8'(r * 16 + c)};
                    compared++;
                    if (bus.out_taps !== exp_taps || bus.out_col !== AW'(c)
                        || bus.out_row !== RW'(r)) begin
                        mismatched++;
                        $display("FAIL %s beat r%0d c%0d: got taps %h col %0d row %0d want %h",
                                 name, r, c, bus.out_taps, bus.out_col, bus.out_row, exp_taps);
                    end
                end
                if (gaps) begin
                    held = bus.out_taps;
                    push(1'b0, 8'hEE, 1'b0);
                    compared++;
                    if (bus.out_valid !== 1'b0 || bus.line_done !== 1'b0
                        || bus.out_taps !== held) begin
                        mismatched++;
                        $display("FAIL %s bubble r%0d c%0d: got v%b ld%b taps %h want 0 0 %h",
                                 name, r, c, bus.out_valid, bus.line_done, bus.out_taps, held);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        bus.clear    = 1'b0;
        bus.in_data  = '0;
        #1;
        compared++;
        if (bus.out_valid !== 1'b0 || bus.out_taps !== 24'h0 || bus.out_col !== '0
            || bus.out_row !== '0 || bus.line_done !== 1'b0) begin
            mismatched++;
            $display("FAIL reset outputs: got v%b taps %h col %0d row %0d ld%b want all 0",
                     bus.out_valid, bus.out_taps, bus.out_col, bus.out_row, bus.line_done);
        end
        do_reset();
    endtask

    task automatic test_stream();
        do_reset();
        stream("stream", 4, 1'b0);
    endtask

    task automatic test_bubbles();
        do_reset();
        stream("bubbles", 4, 1'b1);
    endtask

    task automatic test_rotation();
        do_reset();
        stream("rotation", 6, 1'b0);
    endtask

    task automatic test_clear();
        do_reset();
        stream("pre_clear", 3, 1'b0);
        for (int c = 0; c < 4; c++) push(1'b1, 8'(3 * 16 + c), 1'b0);
        push(1'b0, 8'h00, 1'b1);
        compared++;
        if (bus.out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL clear valid: got %b want 0", bus.out_valid);
        end
        stream("post_clear", 3, 1'b0);
        compared++;
        if (bus.out_taps !== 24'h071727) begin
            mismatched++;
            $display("FAIL clear last beat: got %h want 071727", bus.out_taps);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        stream("pre_reset", 4, 1'b0);
        for (int c = 0; c < 3; c++) push(1'b1, 8'(4 * 16 + c), 1'b0);
        compared++;
        if (bus.out_valid !== 1'b1 || bus.out_taps !== 24'h223242) begin
            mismatched++;
            $display("FAIL pre_reset beat: got v%b taps %h want 1 223242",
                     bus.out_valid, bus.out_taps);
        end
        #2;
        reset = 1'b0;
        #1;
        compared++;
        if (bus.out_valid !== 1'b0 || bus.out_taps !== 24'h0 || bus.out_col !== '0
            || bus.out_row !== '0) begin
            mismatched++;
            $display("FAIL async reset: got v%b taps %h col %0d row %0d want all 0",
                     bus.out_valid, bus.out_taps, bus.out_col, bus.out_row);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        stream("post_reset", 4, 1'b0);
    endtask

    task automatic test_clear_accept();
        do_reset();
        push(1'b1, 8'h31, 1'b0);
        push(1'b1, 8'hAA, 1'b1);
        compared++;
        if (bus.out_valid !== 1'b0 || bus.out_col !== '0 || bus.out_row !== '0) begin
            mismatched++;
            $display("FAIL clear_accept beat: got v%b col %0d row %0d want 0 0 0",
                     bus.out_valid, bus.out_col, bus.out_row);
        end
        for (int c = 1; c < LW; c++) push(1'b1, 8'(c), 1'b0);
        for (int c = 0; c < LW; c++) push(1'b1, 8'(16 + c), 1'b0);
        push(1'b1, 8'h20, 1'b0);
        compared++;
        if (bus.out_valid !== 1'b1 || bus.out_taps !== 24'hAA1020 || bus.out_col !== '0
            || bus.out_row !== RW'(2)) begin
            mismatched++;
            $display("FAIL clear_accept r2c0: got v%b taps %h col %0d row %0d want 1 AA1020 0 2",
                     bus.out_valid, bus.out_taps, bus.out_col, bus.out_row);
        end
        push(1'b1, 8'h21, 1'b0);
        compared++;
        if (bus.out_taps !== 24'h011121) begin
            mismatched++;
            $display("FAIL clear_accept r2c1: got %h want 011121", bus.out_taps);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_stream();
        test_bubbles();
        test_rotation();
        test_clear();
        test_async_reset();
        test_clear_accept();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
